// File: rtl/crc_pkg.sv
// Shared types and constants for the serial CRC blocks.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0]  POLY_CRC3  = 3'b011;
    localparam logic [7:0]  POLY_CRC8  = 8'h07;
    localparam logic [15:0] POLY_CRC16 = 16'h1021;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_CHK = 1'b1;

endpackage

// File: rtl/crc_serial_codec_if.sv
// Request/result handshake bundle between the message source and the serial CRC codec.
interface crc_serial_codec_if #(
    parameter int unsigned MSG_W = 7,
    parameter int unsigned CRC_W = 3
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_mode;
    logic [MSG_W-1:0]       in_msg;
    logic [CRC_W-1:0]       in_crc;
    logic                   out_valid;
    logic                   out_ready;
    logic [MSG_W+CRC_W-1:0] out_code;
    logic [CRC_W-1:0]       out_crc;
    logic                   out_err;
    logic                   busy;

    modport master (
        output in_valid, in_mode, in_msg, in_crc, out_ready,
        input  in_ready, out_valid, out_code, out_crc, out_err, busy
    );

    modport slave (
        input  in_valid, in_mode, in_msg, in_crc, out_ready,
        output in_ready, out_valid, out_code, out_crc, out_err, busy
    );
endinterface

// File: rtl/crc_lfsr_step.sv
// Combinational single-bit CRC LFSR update (MSB-first, Galois form).
module crc_lfsr_step
    import crc_pkg::*;
#(
    parameter int unsigned      CRC_W = 3,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(POLY_CRC3)
) (
    input  logic [CRC_W-1:0] crc,
    input  logic             din,
    output logic [CRC_W-1:0] crc_next_c
);
    logic fb_c;

    assign fb_c = crc[CRC_W-1] ^ din;

    // A 1-bit register has no lower bits to shift, so it just takes the feedback.
    generate
        if (CRC_W == 1) begin : g_w1
            assign crc_next_c = fb_c;
        end else begin : g_wn
            assign crc_next_c = {crc[CRC_W-2:0], 1'b0} ^ (fb_c ? POLY : '0);
        end
    endgenerate

endmodule

// File: rtl/crc_serial_codec.sv
// Bit-serial CRC encoder/checker: one word per handshake, shifted MSB-first one bit per clock.
module crc_serial_codec
    import crc_pkg::*;
#(
    parameter int unsigned      MSG_W = 7,
    parameter int unsigned      CRC_W = 3,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(POLY_CRC3),
    parameter logic [CRC_W-1:0] INIT  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    crc_serial_codec_if.slave   bus
);
    localparam int unsigned     CNT_W    = (MSG_W > 1) ? $clog2(MSG_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_W - 1);

    generate
        if (MSG_W == 0 || CRC_W == 0) begin : g_bad_param
            $error("crc_serial_codec: MSG_W and CRC_W must both be >= 1");
        end
    endgenerate

    state_t           state;
    logic [MSG_W-1:0] msg_q;
    logic             mode_q;
    logic [CRC_W-1:0] rcrc_q;
    logic [CRC_W-1:0] crc_q;
    logic [CNT_W-1:0] count;
    logic [CRC_W-1:0] crc_nxt_c;

    // count runs MSG_W-1 down to 0, so indexing by it walks the word MSB-first.
    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .crc        (crc_q),
        .din        (msg_q[count]),
        .crc_next_c (crc_nxt_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            msg_q         <= '0;
            mode_q        <= MODE_ENC;
            rcrc_q        <= '0;
            crc_q         <= INIT;
            count         <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_code  <= '0;
            bus.out_crc   <= '0;
            bus.out_err   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        msg_q        <= bus.in_msg;
                        mode_q       <= bus.in_mode;
                        rcrc_q       <= bus.in_crc;
                        crc_q        <= INIT;
                        count        <= CNT_LAST;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= SHIFT;
                    end
                end
                SHIFT: begin
                    crc_q <= crc_nxt_c;
                    if (count == '0) begin
                        bus.out_valid <= 1'b1;
                        bus.out_crc   <= crc_nxt_c;
                        bus.out_code  <= {msg_q, crc_nxt_c};
                        bus.out_err   <= (mode_q == MODE_CHK) && (crc_nxt_c != rcrc_q);
                        state         <= DONE;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Result held stable until the consumer takes it.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_serial_codec.sv
// Directed self-checking bench for crc_serial_codec (CRC-3 default and a 32/8 configuration).
module tb_crc_serial_codec;
    import crc_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat;

    crc_serial_codec_if #(.MSG_W(7),  .CRC_W(3)) a ();
    crc_serial_codec_if #(.MSG_W(32), .CRC_W(8)) b ();

    crc_serial_codec #(
        .MSG_W (7),
        .CRC_W (3),
        .POLY  (3'b011),
        .INIT  (3'b000)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a)
    );

    crc_serial_codec #(
        .MSG_W (32),
        .CRC_W (8),
        .POLY  (8'h07),
        .INIT  (8'h00)
    ) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Long division of msg * x^8 by x^8 + POLY.
    function automatic logic [7:0] ref_crc8(input logic [31:0] m, input logic [7:0] poly);
        logic [39:0] r;
        r = {m, 8'h00};
        for (int i = 39; i >= 8; i--) begin
            if (r[i]) r[i -: 9] = r[i -: 9] ^ {1'b1, poly};
        end
        return r[7:0];
    endfunction

    task automatic send_a(input logic mode, input logic [6:0] msg, input logic [2:0] rc);
        int w = 0;
        while (!a.in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        a.in_valid = 1'b1;
        a.in_mode  = mode;
        a.in_msg   = msg;
        a.in_crc   = rc;
        @(posedge clk); #1;
        a.in_valid = 1'b0;
        a.in_msg   = ~msg;
        a.in_crc   = ~rc;
        a.in_mode  = ~mode;
    endtask

    task automatic wait_a(output int l);
        l = 0;
        while (!a.out_valid && l < 100) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic handshake_a(input string tag);
        a.out_ready = 1'b1;
        @(posedge clk); #1;
        a.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, a.out_valid, 1'b0);
        chk({tag, "_ready_back"}, a.in_ready, 1'b1);
    endtask

    task automatic result_a(input string tag, input logic [6:0] msg, input logic [2:0] crc,
                            input logic err);
        int l;
        wait_a(l);
        chk({tag, "_latency"}, l, 7);
        chk({tag, "_crc"}, a.out_crc, crc);
        chk({tag, "_code"}, a.out_code, {msg, crc});
        chk({tag, "_err"}, a.out_err, err);
        handshake_a(tag);
    endtask

    initial begin
        rst_n       = 1'b0;
        a.in_valid  = 1'b0;
        a.in_mode   = MODE_ENC;
        a.in_msg    = '0;
        a.in_crc    = '0;
        a.out_ready = 1'b0;
        b.in_valid  = 1'b0;
        b.in_mode   = MODE_ENC;
        b.in_msg    = '0;
        b.in_crc    = '0;
        b.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", a.in_ready, 1'b1);
        chk("rst_out_valid", a.out_valid, 1'b0);
        chk("rst_out_code", a.out_code, 10'd0);
        chk("rst_out_crc", a.out_crc, 3'd0);
        chk("rst_out_err", a.out_err, 1'b0);
        chk("rst_busy", a.busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Encode vectors
        send_a(MODE_ENC, 7'b1101011, 3'b000);
        chk("shift_busy", a.busy, 1'b1);
        chk("shift_in_ready", a.in_ready, 1'b0);
        result_a("enc_1101011", 7'b1101011, 3'b110, 1'b0);
        send_a(MODE_ENC, 7'b0000001, 3'b000);
        result_a("enc_0000001", 7'b0000001, 3'b011, 1'b0);
        send_a(MODE_ENC, 7'b1000000, 3'b000);
        result_a("enc_1000000", 7'b1000000, 3'b100, 1'b0);
        send_a(MODE_ENC, 7'b0000000, 3'b000);
        result_a("enc_zero", 7'b0000000, 3'b000, 1'b0);
        send_a(MODE_ENC, 7'b1101011, 3'b111);
        result_a("enc_err_masked", 7'b1101011, 3'b110, 1'b0);

        // Check mode
        send_a(MODE_CHK, 7'b1101011, 3'b110);
        result_a("chk_good", 7'b1101011, 3'b110, 1'b0);
        send_a(MODE_CHK, 7'b1101011, 3'b111);
        result_a("chk_bad", 7'b1101011, 3'b110, 1'b1);

        // Backpressure: result must hold while in_valid pulses are ignored
        send_a(MODE_ENC, 7'b1000000, 3'b000);
        wait_a(lat);
        chk("bp_latency", lat, 7);
        for (int i = 0; i < 10; i++) begin
            a.in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            chk("bp_valid", a.out_valid, 1'b1);
            chk("bp_crc", a.out_crc, 3'b100);
            chk("bp_code", a.out_code, {7'b1000000, 3'b100});
            chk("bp_in_ready", a.in_ready, 1'b0);
        end
        a.in_valid = 1'b0;
        handshake_a("bp_release");
        send_a(MODE_ENC, 7'b0000001, 3'b000);
        result_a("bp_next", 7'b0000001, 3'b011, 1'b0);

        // Reset in the middle of shifting
        send_a(MODE_ENC, 7'b1101011, 3'b000);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", a.out_valid, 1'b0);
        chk("midrst_in_ready", a.in_ready, 1'b1);
        chk("midrst_busy", a.busy, 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        send_a(MODE_ENC, 7'b0000001, 3'b000);
        result_a("midrst_next", 7'b0000001, 3'b011, 1'b0);

        // 32-bit message, CRC-8 poly 0x07, ASCII "1234"
        b.in_valid = 1'b1;
        b.in_mode  = MODE_ENC;
        b.in_msg   = 32'h31323334;
        @(posedge clk); #1;
        b.in_valid = 1'b0;
        b.in_msg   = 32'hFFFF_FFFF;
        lat = 0;
        while (!b.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w32_latency", lat, 32);
        chk("w32_crc", b.out_crc, ref_crc8(32'h31323334, 8'h07));
        chk("w32_code", b.out_code, {32'h31323334, ref_crc8(32'h31323334, 8'h07)});
        chk("w32_err", b.out_err, 1'b0);
        b.out_ready = 1'b1;
        @(posedge clk); #1;
        b.out_ready = 1'b0;
        chk("w32_valid_drop", b.out_valid, 1'b0);
        chk("w32_ready_back", b.in_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/crc_serial_codec.md
Name: crc_serial_codec

Overview:
- Parametrised, bit-serial CRC encoder/checker; successor to the combinational 7-bit/3-bit CRC encoder.
- Accepts one message word per valid/ready handshake and shifts it MSB-first through a CRC_W-bit LFSR, one bit per clock.
- Encode mode returns the systematic codeword {msg, crc}. Check mode compares the computed CRC with a received CRC and flags a mismatch.
- Sits between the message source and the channel/serialiser on the EEDC data path.

Parameters:
- MSG_W, 7, message width in bits (>=1)
- CRC_W, 3, CRC width in bits (>=1)
- POLY, 3'b011, generator polynomial without its implicit leading x^CRC_W term (default x^3+x+1)
- INIT, 0, CRC register value loaded at the start of each word

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word
- in_mode  input  1  0 = encode, 1 = check; sampled on accept
- in_msg  input  MSG_W  message word; MSB is shifted first
- in_crc  input  CRC_W  received CRC; used in check mode only
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_code  output  MSG_W+CRC_W  {msg, computed crc}
- out_crc  output  CRC_W  computed CRC
- out_err  output  1  check mode: computed CRC != in_crc; always 0 in encode mode
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Clock and reset: single clock domain, clk; rst_n is asynchronous assert, active-low.
- Reset state: IDLE, crc=INIT, count=0, in_ready=1, out_valid=0, out_code=0, out_crc=0, out_err=0, busy=0.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch msg into the shift register; latch mode and in_crc; crc<=INIT; count<=MSG_W-1; go to SHIFT.
- FSM SHIFT:
  - in_ready=0.
  - Each clock: fb = crc[CRC_W-1] ^ msg_bit(MSB first); crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0). For CRC_W=1, crc<=fb.
  - On count==0: compute the final CRC and go to DONE. Otherwise count decrements.
- FSM DONE:
  - out_valid=1; outputs registered and held stable until out_ready.
  - On out_valid&out_ready: go to IDLE.
  - in_ready returns high on the following cycle; no overlap of accept and result.
- Latency:
  - Word accepted at edge E; the last shift is at edge E+MSG_W.
  - out_valid is high from edge E+MSG_W until the output handshake.
  - Throughput is one word per MSG_W+2 cycles when out_ready is held high.
- Arithmetic equivalence: the result equals (msg * x^CRC_W) mod G when INIT=0, i.e. the remainder of long division with CRC_W appended zeros.
- out_err = (mode==1) && (crc != latched in_crc); it is valid together with out_valid.
- Backpressure: out_ready=0 in DONE holds every output unchanged indefinitely. in_valid is ignored while in_ready=0.
- Reset mid-operation: rst_n low in SHIFT or DONE aborts the word immediately and returns to reset values. There is no partial output.
- Changes on in_msg, in_mode or in_crc after the accept edge have no effect on the result.
- Parameter guard: an elaboration-time check rejects MSG_W<1 or CRC_W<1.

Decomposition:
- Shared package crc_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - localparam POLY_CRC3 = 3'b011
  - localparam POLY_CRC8 = 8'h07
  - localparam POLY_CRC16 = 16'h1021
  - MODE_ENC/MODE_CHK constants
- Sub-module crc_lfsr_step: purely combinational single-bit LFSR update (crc, bit, POLY → next crc). It is instantiated once and reused by other serial CRC blocks.

Test Plan:
- Encode, defaults, in_msg=7'b1101011 -> after 7 shift cycles out_crc=3'b110, out_code=10'b1101011110, out_err=0.
- Encode in_msg=7'b0000001 -> out_crc=3'b011; in_msg=7'b1000000 -> out_crc=3'b100; in_msg=0 -> out_crc=0.
- Check mode, in_msg=7'b1101011: in_crc=3'b110 -> out_err=0; in_crc=3'b111 -> out_err=1 with out_crc=3'b110.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, outputs constant, in_ready=0; in_valid pulses are ignored. Release -> in_ready=1 on the next cycle.
- Reset mid-SHIFT: assert rst_n=0 at shift cycle 3 -> out_valid=0 and in_ready=1 immediately. Next word 7'b0000001 -> correct CRC 3'b011.
- Parameter sweep: MSG_W=32, CRC_W=8, POLY=8'h07, msg="1234" ASCII (0x31323334) -> result matches the reference model, and latency is exactly 32 cycles from accept to out_valid.
